// File: rtl/pdp8l_rkx_iot.sv
// RK8E-class disk controller IOT interface for the PDP-8/L bus.
// Decodes the disk IOTs and hands transfers and seeks to the ARM through a register mailbox.
module pdp8l_rkx_iot #(
  parameter logic [5:0]  DEVCODE = 6'o74,
  parameter int          NDRIVES = 4,
  parameter logic [11:0] VERSION = 12'h006
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        BINIT,
  input  logic        CSTEP,
  input  logic        armwrite,
  input  logic [2:0]  armwaddr,
  input  logic [2:0]  armraddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        iopstart,
  input  logic        iopstop,
  input  logic [11:0] ioopcode,
  input  logic [11:0] cputodev,
  output logic [11:0] devtocpu,
  output logic        AC_CLEAR,
  output logic        IO_SKIP,
  output logic        INT_RQST,
  output logic        ARM_RQST
);

  localparam logic [3:0]  DRV_MASK  = 4'((1 << NDRIVES) - 1);
  localparam logic [11:0] SKIP_MASK = 12'o5677;

  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_DSKP = 3'd1,
    OP_DCLR = 3'd2,
    OP_DLAG = 3'd3,
    OP_DLCA = 3'd4,
    OP_DRST = 3'd5,
    OP_DLDC = 3'd6,
    OP_RSVD = 3'd7
  } iot_op_e;

  logic [11:0] command_q, command_d;
  logic [11:0] diskaddr_q, diskaddr_d;
  logic [11:0] memaddr_q, memaddr_d;
  logic [11:0] status_q, status_d;
  logic [3:0]  seeking_q, seeking_d;
  logic [1:0]  drvsel_q, drvsel_d;
  logic        startio_q, startio_d;
  logic        stbusy_q, stbusy_d;
  logic        enable_q, enable_d;
  logic        done_pend_q, done_pend_d;
  logic        iop_busy_q, iop_busy_d;
  logic        pend_valid_q, pend_valid_d;
  logic [2:0]  pend_addr_q, pend_addr_d;
  logic [11:0] pend_data_q, pend_data_d;
  logic [11:0] devtocpu_q, devtocpu_d;
  logic        ac_clear_q, ac_clear_d;
  logic        io_skip_q, io_skip_d;

  logic        iop_hit;
  logic        stskip;
  logic [1:0]  cmd_drv;
  iot_op_e     iot_op;
  logic        arm_we;
  logic [2:0]  arm_addr;
  logic [11:0] arm_data;
  logic [3:0]  seek_clr;
  logic        unused_wdata;

  assign unused_wdata = ^armwdata[31:12];

  assign iop_hit = CSTEP && iopstart && enable_q && !iop_busy_q &&
                   (ioopcode[11:9] == 3'o6) && (ioopcode[8:3] == DEVCODE);
  assign iot_op  = iot_op_e'(ioopcode[2:0]);
  assign stskip  = |(status_q & SKIP_MASK);
  assign cmd_drv = command_q[2:1];

  // A fresh ARM write always supersedes a held one.
  assign arm_we   = armwrite || pend_valid_q;
  assign arm_addr = armwrite ? armwaddr : pend_addr_q;
  assign arm_data = armwrite ? armwdata[11:0] : pend_data_q;

  always_comb begin
    command_d    = command_q;
    diskaddr_d   = diskaddr_q;
    memaddr_d    = memaddr_q;
    status_d     = status_q;
    seeking_d    = seeking_q;
    drvsel_d     = drvsel_q;
    startio_d    = startio_q;
    stbusy_d     = stbusy_q;
    enable_d     = enable_q;
    done_pend_d  = 1'b0;
    iop_busy_d   = iop_busy_q;
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    devtocpu_d   = devtocpu_q;
    ac_clear_d   = ac_clear_q;
    io_skip_d    = io_skip_q;
    seek_clr     = 4'b0;

    if (done_pend_q) status_d[11] = 1'b1;

    if (CSTEP && iopstop) begin
      iop_busy_d = 1'b0;
      devtocpu_d = 12'b0;
      ac_clear_d = 1'b0;
      io_skip_d  = 1'b0;
    end

    if (iop_hit) begin
      iop_busy_d = 1'b1;
      devtocpu_d = 12'b0;
      ac_clear_d = 1'b0;
      io_skip_d  = 1'b0;
      // The IOP owns this cycle; any ARM write waits one cycle and then wins.
      if (arm_we) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = arm_addr;
        pend_data_d  = arm_data;
      end
      case (iot_op)
        OP_DSKP: io_skip_d = stskip;
        OP_DCLR: begin
          case (cputodev[1:0])
            2'd0: begin
              if (stbusy_q) status_d[6] = 1'b1;
              else          status_d    = 12'b0;
            end
            2'd1: begin
              command_d = 12'b0;
              memaddr_d = 12'b0;
              status_d  = 12'b0;
              startio_d = 1'b1;
              stbusy_d  = 1'b1;
            end
            2'd2: begin
              if (stbusy_q) begin
                status_d[6] = 1'b1;
              end else begin
                command_d  = {3'd3, command_q[8], 8'b0};
                diskaddr_d = 12'b0;
                startio_d  = 1'b1;
                stbusy_d   = 1'b1;
              end
            end
            default: begin
              status_d  = 12'b0;
              startio_d = 1'b1;
            end
          endcase
        end
        OP_DLAG: begin
          if (stbusy_q) begin
            status_d[6] = 1'b1;
          end else if (!DRV_MASK[cmd_drv]) begin
            status_d[1] = 1'b1;
          end else begin
            ac_clear_d = 1'b1;
            diskaddr_d = cputodev;
            status_d   = 12'b0;
            drvsel_d   = cmd_drv;
            startio_d  = 1'b1;
            stbusy_d   = 1'b1;
            if (command_q[11:9] == 3'd3) seeking_d[cmd_drv] = 1'b1;
          end
        end
        OP_DLCA: begin
          if (stbusy_q) begin
            status_d[6] = 1'b1;
          end else begin
            ac_clear_d = 1'b1;
            memaddr_d  = cputodev;
          end
        end
        OP_DRST: begin
          ac_clear_d = 1'b1;
          devtocpu_d = {status_q[11], seeking_q[cmd_drv], status_q[9:0]};
        end
        OP_DLDC: begin
          if (stbusy_q) begin
            status_d[6] = 1'b1;
          end else begin
            ac_clear_d = 1'b1;
            command_d  = cputodev;
            status_d   = 12'b0;
          end
        end
        default: ;
      endcase
    end else begin
      pend_valid_d = 1'b0;
      if (arm_we) begin
        case (arm_addr)
          3'd1: command_d  = arm_data;
          3'd2: diskaddr_d = arm_data;
          3'd3: memaddr_d  = arm_data;
          3'd4: status_d   = {arm_data[11:7], status_d[6], arm_data[5:0]};
          3'd5: begin
            enable_d  = arm_data[0];
            startio_d = arm_data[1];
            stbusy_d  = arm_data[2];
          end
          3'd6: begin
            seek_clr    = seeking_q & arm_data[3:0];
            seeking_d   = seeking_q & ~arm_data[3:0];
            done_pend_d = (|seek_clr) && command_q[7];
          end
          default: ;
        endcase
      end
    end

    seeking_d = seeking_d & DRV_MASK;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET || BINIT) begin
      command_q    <= 12'b0;
      diskaddr_q   <= 12'b0;
      memaddr_q    <= 12'b0;
      status_q     <= 12'b0;
      seeking_q    <= 4'b0;
      drvsel_q     <= 2'b0;
      startio_q    <= 1'b0;
      stbusy_q     <= 1'b0;
      enable_q     <= RESET ? 1'b0 : enable_q;
      done_pend_q  <= 1'b0;
      iop_busy_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= 3'b0;
      pend_data_q  <= 12'b0;
      devtocpu_q   <= 12'b0;
      ac_clear_q   <= 1'b0;
      io_skip_q    <= 1'b0;
    end else begin
      command_q    <= command_d;
      diskaddr_q   <= diskaddr_d;
      memaddr_q    <= memaddr_d;
      status_q     <= status_d;
      seeking_q    <= seeking_d;
      drvsel_q     <= drvsel_d;
      startio_q    <= startio_d;
      stbusy_q     <= stbusy_d;
      enable_q     <= enable_d;
      done_pend_q  <= done_pend_d;
      iop_busy_q   <= iop_busy_d;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      devtocpu_q   <= devtocpu_d;
      ac_clear_q   <= ac_clear_d;
      io_skip_q    <= io_skip_d;
    end
  end

  always_comb begin
    case (armraddr)
      3'd0:    armrdata = {16'h524B, 4'h2, VERSION};
      3'd1:    armrdata = {20'b0, command_q};
      3'd2:    armrdata = {20'b0, diskaddr_q};
      3'd3:    armrdata = {20'b0, memaddr_q};
      3'd4:    armrdata = {20'b0, status_q};
      3'd5:    armrdata = {29'b0, stbusy_q, startio_q, enable_q};
      3'd6:    armrdata = {28'b0, seeking_q};
      3'd7:    armrdata = {30'b0, drvsel_q};
      default: armrdata = 32'hDEADBEEF;
    endcase
  end

  assign devtocpu = devtocpu_q;
  assign AC_CLEAR = ac_clear_q;
  assign IO_SKIP  = io_skip_q;
  assign INT_RQST = command_q[8] && stskip;
  assign ARM_RQST = startio_q;

endmodule

// File: tb/tb_pdp8l_rkx_iot.sv
// Bench for pdp8l_rkx_iot: directed scenarios plus randomized IOT/ARM traffic
// checked against a register-level behavioural model of the controller.
module tb_pdp8l_rkx_iot;

   localparam int NDRV = 2;

   logic        clk = 1'b0;
   logic        reset, binit, cstep, armwrite, iopstart, iopstop;
   logic [2:0]  armwaddr, armraddr;
   logic [31:0] armwdata, armrdata;
   logic [11:0] ioopcode, cputodev, devtocpu;
   logic        acClear, ioSkip, intRqst, armRqst;

   int testsRun = 0;
   int testsFailed = 0;

   // behavioural model of the controller's programmer-visible state
   logic [11:0] mCmd, mDa, mMa, mSt;
   logic [3:0]  mSeek;
   logic [1:0]  mDrv;
   logic        mStart, mBusy, mEn;
   logic [11:0] expDtc;
   logic        expAcc, expSkip;

   always #5 clk = ~clk;

   pdp8l_rkx_iot #(.DEVCODE(6'o74), .NDRIVES(NDRV), .VERSION(12'h006)) dut (
      .CLOCK(clk), .RESET(reset), .BINIT(binit), .CSTEP(cstep),
      .armwrite(armwrite), .armwaddr(armwaddr), .armraddr(armraddr),
      .armwdata(armwdata), .armrdata(armrdata),
      .iopstart(iopstart), .iopstop(iopstop), .ioopcode(ioopcode),
      .cputodev(cputodev), .devtocpu(devtocpu),
      .AC_CLEAR(acClear), .IO_SKIP(ioSkip), .INT_RQST(intRqst), .ARM_RQST(armRqst)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic modelReset(input logic keepEnable);
      mCmd = '0; mDa = '0; mMa = '0; mSt = '0; mSeek = '0; mDrv = '0;
      mStart = 1'b0; mBusy = 1'b0;
      if (!keepEnable) mEn = 1'b0;
   endtask

   function automatic logic statusSkips(input logic [11:0] st);
      return st[11] | st[9] | st[8] | st[7] | (st[5:0] != 6'd0);
   endfunction

   // effect of one decoded disk IOT on the model, plus the bus response it owes the CPU
   task automatic modelIop(input logic [2:0] op, input logic [11:0] ac);
      int drive;
      drive = int'(mCmd[2:1]);
      expDtc = '0; expAcc = 1'b0; expSkip = 1'b0;
      case (op)
         3'd1: expSkip = statusSkips(mSt);
         3'd2: begin
            if (ac[1:0] == 2'd0) begin
               if (mBusy) mSt[6] = 1'b1; else mSt = '0;
            end else if (ac[1:0] == 2'd1) begin
               mCmd = '0; mMa = '0; mSt = '0; mStart = 1'b1; mBusy = 1'b1;
            end else if (ac[1:0] == 2'd2) begin
               if (mBusy) mSt[6] = 1'b1;
               else begin
                  mCmd = 12'o3000 | (mCmd & 12'o0400);
                  mDa = '0; mStart = 1'b1; mBusy = 1'b1;
               end
            end else begin
               mSt = '0; mStart = 1'b1;
            end
         end
         3'd3: begin
            if (mBusy) mSt[6] = 1'b1;
            else if (drive >= NDRV) mSt[1] = 1'b1;
            else begin
               expAcc = 1'b1; mDa = ac; mSt = '0; mDrv = mCmd[2:1];
               mStart = 1'b1; mBusy = 1'b1;
               if (mCmd[11:9] == 3'd3) mSeek[drive] = 1'b1;
            end
         end
         3'd4: begin
            if (mBusy) mSt[6] = 1'b1;
            else begin expAcc = 1'b1; mMa = ac; end
         end
         3'd5: begin
            expAcc = 1'b1;
            expDtc = mSt;
            expDtc[10] = (drive < NDRV) ? mSeek[drive] : 1'b0;
         end
         3'd6: begin
            if (mBusy) mSt[6] = 1'b1;
            else begin expAcc = 1'b1; mCmd = ac; mSt = '0; end
         end
         default: ;
      endcase
   endtask

   task automatic modelArm(input logic [2:0] a, input logic [11:0] d);
      case (a)
         3'd1: mCmd = d;
         3'd2: mDa = d;
         3'd3: mMa = d;
         3'd4: mSt = (d & ~12'o0100) | (mSt & 12'o0100);
         3'd5: begin mEn = d[0]; mStart = d[1]; mBusy = d[2]; end
         3'd6: begin
            if (((mSeek & d[3:0]) != 4'd0) && mCmd[7]) mSt[11] = 1'b1;
            mSeek = mSeek & ~d[3:0];
         end
         default: ;
      endcase
   endtask

   task automatic readReg(input logic [2:0] a, output logic [31:0] d);
      armraddr = a;
      #1;
      d = armrdata;
   endtask

   task automatic checkRegs(input string tag);
      logic [31:0] d;
      readReg(3'd1, d); checkOutput({tag, " command"}, d, {20'b0, mCmd});
      readReg(3'd2, d); checkOutput({tag, " diskaddr"}, d, {20'b0, mDa});
      readReg(3'd3, d); checkOutput({tag, " memaddr"}, d, {20'b0, mMa});
      readReg(3'd4, d); checkOutput({tag, " status"}, d, {20'b0, mSt});
      readReg(3'd5, d); checkOutput({tag, " ctrl"}, d, {29'b0, mBusy, mStart, mEn});
      readReg(3'd6, d); checkOutput({tag, " seeking"}, d, {28'b0, mSeek});
      readReg(3'd7, d); checkOutput({tag, " drvsel"}, d, {30'b0, mDrv});
      checkOutput({tag, " ARM_RQST"}, {31'b0, armRqst}, {31'b0, mStart});
      checkOutput({tag, " INT_RQST"}, {31'b0, intRqst}, {31'b0, mCmd[8] & statusSkips(mSt)});
   endtask

   task automatic armWrite(input logic [2:0] a, input logic [11:0] d);
      @(negedge clk);
      armwrite = 1'b1; armwaddr = a; armwdata = {20'hABCDE, d};
      @(negedge clk);
      armwrite = 1'b0;
      @(negedge clk);
      modelArm(a, d);
   endtask

   // one complete IOP: start strobe, hold, then stop strobe
   task automatic applyStimulus(input string tag, input logic [11:0] opc, input logic [11:0] ac);
      if (opc[11:9] == 3'o6 && opc[8:3] == 6'o74 && mEn) modelIop(opc[2:0], ac);
      else begin expDtc = '0; expAcc = 1'b0; expSkip = 1'b0; end
      @(negedge clk);
      cstep = 1'b1; iopstart = 1'b1; ioopcode = opc; cputodev = ac;
      @(negedge clk);
      cstep = 1'b0; iopstart = 1'b0;
      checkOutput({tag, " devtocpu"}, {20'b0, devtocpu}, {20'b0, expDtc});
      checkOutput({tag, " AC_CLEAR"}, {31'b0, acClear}, {31'b0, expAcc});
      checkOutput({tag, " IO_SKIP"}, {31'b0, ioSkip}, {31'b0, expSkip});
      @(negedge clk);
      checkOutput({tag, " AC_CLEAR held"}, {31'b0, acClear}, {31'b0, expAcc});
      cstep = 1'b1; iopstop = 1'b1;
      @(negedge clk);
      cstep = 1'b0; iopstop = 1'b0;
      checkOutput({tag, " bus cleared"}, {19'b0, acClear, ioSkip, devtocpu}, 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      reset = 1'b1; binit = 1'b0; cstep = 1'b0; armwrite = 1'b0;
      armwaddr = '0; armraddr = '0; armwdata = '0;
      iopstart = 1'b0; iopstop = 1'b0; ioopcode = '0; cputodev = '0;
      mEn = 1'b0;
      modelReset(1'b0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      readReg(3'd0, d); checkOutput("id", d, 32'h524B2006);
      checkRegs("reset");
      checkOutput("reset bus", {19'b0, acClear, ioSkip, devtocpu}, 32'd0);

      armWrite(3'd5, 12'd1);
      applyStimulus("dlag basic", 12'o6743, 12'o0123);
      checkRegs("dlag basic");

      armWrite(3'd5, 12'd1);
      applyStimulus("dldc drv3", 12'o6746, 12'o0006);
      applyStimulus("dlag nxdrive", 12'o6743, 12'o0555);
      applyStimulus("dskp dser", 12'o6741, 12'o0000);
      checkRegs("nxdrive");

      applyStimulus("dldc seek1", 12'o6746, 12'o3602);
      applyStimulus("dlag seek1", 12'o6743, 12'o0010);
      armWrite(3'd5, 12'd1);
      applyStimulus("dldc seek0", 12'o6746, 12'o3600);
      applyStimulus("dlag seek0", 12'o6743, 12'o0020);
      checkRegs("two seeks");
      armWrite(3'd6, 12'd2);
      checkRegs("seek1 done");

      armWrite(3'd6, 12'd1);
      armWrite(3'd4, 12'd0);
      applyStimulus("dldc busy", 12'o6746, 12'o1234);
      applyStimulus("drst", 12'o6745, 12'o0000);
      checkRegs("cbsy");

      armWrite(3'd5, 12'd1);
      @(negedge clk);
      cstep = 1'b1; iopstart = 1'b1; ioopcode = 12'o6744; cputodev = 12'o0100;
      armwrite = 1'b1; armwaddr = 3'd3; armwdata = 32'h0000_01FF;
      @(negedge clk);
      cstep = 1'b0; iopstart = 1'b0; armwrite = 1'b0;
      readReg(3'd3, d); checkOutput("collide iop first", d, 32'o0100);
      checkOutput("collide AC_CLEAR", {31'b0, acClear}, 32'd1);
      @(negedge clk);
      readReg(3'd3, d); checkOutput("collide arm wins", d, 32'o0777);
      cstep = 1'b1; iopstop = 1'b1;
      @(negedge clk);
      cstep = 1'b0; iopstop = 1'b0;
      mMa = 12'o0777;
      checkRegs("collide");

      applyStimulus("wrong devcode", 12'o6751, 12'o0000);
      armWrite(3'd5, 12'd0);
      applyStimulus("disabled", 12'o6743, 12'o1111);
      checkRegs("disabled");

      armWrite(3'd5, 12'd1);
      for (int i = 0; i < 40; i++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 2)       armWrite(3'd5, {9'b0, 2'($urandom_range(0, 3)), 1'b1});
         else if (r == 2) armWrite(3'd1, 12'($urandom));
         else if (r == 3) armWrite(3'd6, 12'($urandom_range(0, 15)));
         else if (r == 4) armWrite(3'd4, 12'($urandom));
         applyStimulus($sformatf("rand%0d", i), {3'o6, 6'o74, 3'($urandom_range(0, 7))}, 12'($urandom));
         checkRegs($sformatf("rand%0d", i));
      end

      armWrite(3'd5, 12'd1);
      applyStimulus("pre-binit dldc", 12'o6746, 12'o0000);
      applyStimulus("pre-binit dlag", 12'o6743, 12'o0042);
      @(negedge clk); binit = 1'b1;
      @(negedge clk); binit = 1'b0;
      modelReset(1'b1);
      checkRegs("binit");

      applyStimulus("pre-reset dlag", 12'o6743, 12'o0077);
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      modelReset(1'b0);
      checkRegs("mid reset");

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
